// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/decode/execute/writeback sequencer for the MIPS-subset core.
// Define PC_SEQ_INSTR_COUNT_EN to add the saturating `retired` instruction counter.
module pc_sequencer #(
    parameter int               OPW     = 6,
    parameter logic [OPW-1:0]   HALT_OP = OPW'(6'b111111)
`ifdef PC_SEQ_INSTR_COUNT_EN
    ,
    parameter int               CW      = 16
`endif
) (
    input  logic           clk,
    input  logic           clr,
    input  logic           start,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           imem_ack,
    output logic           imem_req,
    output logic           ir_load,
    output logic           pc_en,
    output logic           pc_src,
    output logic           reg_write,
    output logic           mem_write,
    output logic           busy,
    output logic           halted
`ifdef PC_SEQ_INSTR_COUNT_EN
    ,
    output logic [CW-1:0]  retired
`endif
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(6'b000000);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(6'b000100);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(6'b000101);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(6'b001000);
    localparam logic [OPW-1:0] OP_LW    = OPW'(6'b100011);
    localparam logic [OPW-1:0] OP_SW    = OPW'(6'b101011);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        WB,
        HALT
    } state_t;

    state_t state_q;
    state_t state_d;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // The PC advances only at the end of an instruction, so it holds the
    // current instruction's address for the whole FETCH..WB sequence.
    always_comb begin
        state_d   = state_q;
        imem_req  = 1'b0;
        ir_load   = 1'b0;
        pc_en     = 1'b0;
        pc_src    = 1'b0;
        reg_write = 1'b0;
        mem_write = 1'b0;
        busy      = 1'b1;
        halted    = 1'b0;

        case (state_q)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    ir_load = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                if (opcode == HALT_OP) begin
                    state_d = HALT;
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = FETCH;
                case (opcode)
                    OP_BEQ: begin
                        pc_en  = 1'b1;
                        pc_src = zero;
                    end
                    OP_BNE: begin
                        pc_en  = 1'b1;
                        pc_src = ~zero;
                    end
                    OP_SW: begin
                        pc_en     = 1'b1;
                        mem_write = 1'b1;
                    end
                    OP_RTYPE, OP_ADDI, OP_LW: begin
                        state_d = WB;
                    end
                    default: begin
                        pc_en = 1'b1;
                    end
                endcase
            end
            WB: begin
                reg_write = 1'b1;
                pc_en     = 1'b1;
                state_d   = FETCH;
            end
            HALT: begin
                busy   = 1'b0;
                halted = 1'b1;
            end
            default: begin
                busy    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

`ifdef PC_SEQ_INSTR_COUNT_EN
    // One count per retired instruction; sticks at all-ones rather than wrapping.
    always_ff @(posedge clk) begin
        if (clr) begin
            retired <= '0;
        end else if (pc_en && (retired != {CW{1'b1}})) begin
            retired <= retired + 1'b1;
        end
    end
`endif

endmodule
